// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: frames 11-bit packets, folds E0/F0 prefixes into one event, buffers events in a FWFT FIFO.
// Latency: event visible SYNC_STAGES+2 clk cycles after the stop-bit falling edge on the pin.
// Backpressure: evt_valid/evt_ready pop port; a push into a full FIFO is dropped and sets sticky overflow.
// Optional macro PS2_TIMEOUT_EN: abort a stalled frame after TIMEOUT_CYCLES idle cycles mid-frame.
module ps2_key_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [9:0]                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizers and edge detect
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   prev_clk_q, prev_clk_d;
  logic                   sync_clk, sync_dat, fall;

  // Frame receiver
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic        byte_vld_q, byte_vld_d;
  logic [7:0]  byte_q, byte_d;
  logic        frame_bad;
  logic        abort;

  // Prefix flags and sticky errors
  logic ext_q, ext_d, brk_q, brk_d;
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;

  // Event FIFO
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, full, push_acc;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Idle-time counter while a frame is in progress; any falling edge restarts it
  always_comb begin
    to_cnt_d = '0;
    if (state_q != IDLE && !fall && !abort) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign abort = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  // Timeout counter register
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dat = dat_sync_q[SYNC_STAGES-1];
  assign fall     = prev_clk_q & ~sync_clk;

  // Shift raw pins into the synchronizer chains
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    prev_clk_d = sync_clk;
  end

  // Frame FSM next state
  always_comb begin
    state_d = state_q;
    if (fall) begin
      unique case (state_q)
        IDLE:    if (!sync_dat) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (abort) state_d = IDLE;
  end

  // Frame FSM datapath: shift data, capture parity, check stop, flag a completed byte
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    frame_bad  = 1'b0;
    if (fall && !abort) begin
      unique case (state_q)
        IDLE: if (!sync_dat) bit_cnt_d = 3'd0;
        DATA: begin
          shift_d   = {sync_dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = sync_dat;
        STOP: begin
          if ((^{shift_q, par_q}) && sync_dat) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix folding, FIFO push/pop and sticky error flags
  always_comb begin
    push     = byte_vld_q && (byte_q != BYTE_EXT) && (byte_q != BYTE_BRK);
    pop      = evt_valid && evt_ready;
    full     = (count_q == CW'(FIFO_DEPTH));
    push_acc = push && (!full || pop);

    ext_d = ext_q;
    brk_d = brk_q;
    if (frame_bad || abort) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == BYTE_EXT)      ext_d = 1'b1;
      else if (byte_q == BYTE_BRK) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = {brk_q, ext_q, byte_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_acc && !pop)      count_d = count_q + 1'b1;
    else if (!push_acc && pop) count_d = count_q - 1'b1;

    // Clear wins over a same-cycle set
    overflow_d  = clr_err ? 1'b0 : (overflow_q  | (push && !push_acc));
    frame_err_d = clr_err ? 1'b0 : (frame_err_q | frame_bad);
  end

  // All state registers; synchronizers preset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      prev_clk_q  <= 1'b1;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      prev_clk_q  <= prev_clk_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign evt_count = count_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed and randomized bench for ps2_key_fifo against a queue-based event model.
// Latency: checks the SYNC_STAGES+2 cycle stop-edge-to-event delay explicitly.
// Backpressure: exercises full FIFO, overflow, simultaneous push/pop and sticky clears.
module tb_ps2_key_fifo;

  localparam int DEPTH = 8;
  localparam int H     = 8;   // PS/2 half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [9:0] evt_data;
  logic [3:0] evt_count;
  logic       overflow;
  logic       frame_err;
  logic       clr_err = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [9:0] mq[$];
  bit m_ext, m_brk, m_ovf, m_ferr;

  ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .frame_err(frame_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(H); ps2_clk = 1'b0;
    cyc(H); ps2_clk = 1'b1;
  endtask

  // Drives start, data, parity, then pulls the clock low for the stop bit and returns
  task automatic frame_to_stop(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_data = 1'b1;
    cyc(H); ps2_clk = 1'b0;
  endtask

  task automatic frame_end();
    cyc(H); ps2_clk = 1'b1;
    cyc(H);
  endtask

  // Model: what one received byte means to the event stream
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    frame_to_stop(b, bad_par);
    frame_end();
    model_byte(b, !bad_par);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(evt_count), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(evt_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, ".head"}, 32'(evt_data), 32'(mq[0]));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, ".data"}, 32'(evt_data), 32'(mq[0]));
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    m_ovf = 0; m_ferr = 0;
  endtask

  initial begin
    logic [7:0] b;
    bit bad;

    // Reset values
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst.valid", 32'(evt_valid), 0);
    chk("rst.count", 32'(evt_count), 0);
    chk("rst.data", 32'(evt_data), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.ferr", 32'(frame_err), 0);

    // 1: single make code, exact latency from the stop-bit falling edge
    frame_to_stop(8'h1D, 0);
    cyc(3);
    chk("lat.valid_early", 32'(evt_valid), 0);
    cyc(1);
    chk("lat.valid", 32'(evt_valid), 1);
    chk("lat.data", 32'(evt_data), 32'h01D);
    chk("lat.count", 32'(evt_count), 1);
    frame_end();
    model_byte(8'h1D, 1);
    pop_chk("t1.pop");

    // 2: extended make then extended break; prefixes alone create nothing
    send_frame(8'hE0, 0);
    chk("t2.prefix_only", 32'(evt_valid), 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    chk("t2.count", 32'(evt_count), 2);
    chk("t2.ext", 32'(evt_data), 32'h175);
    pop_chk("t2.pop1");
    chk("t2.brk", 32'(evt_data), 32'h375);
    pop_chk("t2.pop2");

    // 3: bad parity, clear, then good frame
    send_frame(8'h1D, 1);
    chk("t3.ferr", 32'(frame_err), 1);
    chk("t3.noevt", 32'(evt_valid), 0);
    pulse_clr();
    chk("t3.ferr_clr", 32'(frame_err), 0);
    send_frame(8'h1C, 0);
    chk("t3.data", 32'(evt_data), 32'h01C);
    pop_chk("t3.pop");

    // 4: fill past capacity, then simultaneous push/pop while full
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    chk("t4.count", 32'(evt_count), DEPTH);
    chk("t4.ovf", 32'(overflow), 1);
    chk("t4.head", 32'(evt_data), 32'h001);
    pulse_clr();
    frame_to_stop(8'h0A, 0);
    cyc(3);
    chk("t4.head_pre", 32'(evt_data), 32'h001);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    void'(mq.pop_front());
    frame_end();
    model_byte(8'h0A, 1);
    chk("t4.count_full", 32'(evt_count), DEPTH);
    chk("t4.ovf_kept0", 32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) pop_chk("t4.drain");
    chk_state("t4.empty");
    pop_chk("t4.pop_empty");
    chk("t4.count_empty", 32'(evt_count), 0);

    // Randomized frames, prefixes, parity errors, pops and clears
    for (int n = 0; n < 30; n++) begin
      case ($urandom % 8)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(1, 255));
      endcase
      bad = (($urandom % 7) == 0);
      send_frame(b, bad);
      chk_state("rnd.state");
      for (int p = 0; p < int'($urandom % 3); p++) pop_chk("rnd.pop");
      if (($urandom % 6) == 0) begin
        pulse_clr();
        chk_state("rnd.clr");
      end
    end

    // 5: reset mid-frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    mq.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
    chk("t5.valid", 32'(evt_valid), 0);
    chk("t5.count", 32'(evt_count), 0);
    chk("t5.data", 32'(evt_data), 0);
    chk("t5.ovf", 32'(overflow), 0);
    chk("t5.ferr", 32'(frame_err), 0);
    send_frame(8'h6B, 0);
    chk("t5.data_after", 32'(evt_data), 32'h06B);
    pop_chk("t5.pop");

    // 6: truncated frame, long idle, then a full frame
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    cyc(120);
    frame_to_stop(8'h72, 0);
    frame_end();
`ifdef PS2_TIMEOUT_EN
    chk("t6.data", 32'(evt_data), 32'h072);
    chk("t6.ferr", 32'(frame_err), 0);
`else
    chk("t6.noevt", 32'(evt_valid), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
Synthesizable PS/2 keyboard receiver for the 2048 board top. It samples the PS2_clk/PS2_data pins and frames 11-bit PS/2 packets. It folds the E0 (extended) and F0 (break) prefixes into one key event and buffers events in a parametrised FIFO behind a valid/ready pop port. It replaces ad-hoc single-byte scancode latching, so game logic can consume direction keys without losing presses.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
SYNC_STAGES, 2, synchronizer flops on ps2_clk and ps2_data; >= 2
TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before receiver abort (1 ms at 100 MHz); used only with PS2_TIMEOUT_EN

Ports:
clk  in  1  system clock (100 MHz on board)
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pop strobe; pops when evt_valid & evt_ready
evt_data  out  10  head event {brk, ext, code[7:0]}, first-word-fall-through
evt_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: an event was dropped because the FIFO was full
frame_err  out  1  sticky: parity or stop-bit error seen
clr_err  in  1  clears overflow and frame_err

Behaviour:
- Reset: evt_valid=0, evt_count=0, overflow=0, frame_err=0, evt_data=0. FSM goes to IDLE; ext and brk flags cleared; FIFO pointers zeroed; synchronizer chains preset to 1 (bus idle).
- Edge detect: fall = prev_sync_clk & ~sync_clk. Every frame step below advances only on a cycle with fall=1.
- IDLE: on fall with data=0 (start bit), clear bit counter and go to DATA. On fall with data=1, stay in IDLE (spurious edge).
- DATA: shift data in LSB first. After the 8th bit, go to PARITY.
- PARITY: store the bit, then go to STOP. Parity is odd: the 8 data bits plus the parity bit must contain an odd number of ones.
- STOP: sample the stop bit, then return to IDLE. If parity is good and stop=1, the byte is complete on this cycle (cycle N). Otherwise set frame_err and clear ext and brk; no event is produced.
- Byte decode at cycle N:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {brk, ext, byte} and clears ext and brk.
- Push is registered: evt_valid and evt_count reflect the new entry at cycle N+1. Pin-to-event latency is SYNC_STAGES+2 cycles after the stop-bit falling edge.
- Pop: on evt_valid & evt_ready, the head advances on the next clock. evt_ready while empty is ignored.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets overflow.
  - A push and pop in the same cycle while full: both are accepted and the count is unchanged.
- Empty FIFO with simultaneous push and pop: the pop is ignored and the push is accepted.
- Pointers wrap modulo FIFO_DEPTH. evt_count ranges 0..FIFO_DEPTH.
- clr_err takes priority over a same-cycle set: both flags read 0 next cycle.
- rst mid-frame aborts the frame and discards the partial byte and prefixes. rst also empties the FIFO.

Optional Feature:
PS2_TIMEOUT_EN
- Defined: a counter runs whenever the FSM is not in IDLE. It clears on each fall. On reaching TIMEOUT_CYCLES, the FSM returns to IDLE and ext and brk are cleared. frame_err is not set. This resynchronises after a glitch or hot-plug.
- Undefined: no counter. A truncated frame stays in progress until further edges arrive, and the next frame may misalign.

Test Plan:
1. Frame 0x1D (start 0, data LSB first, parity 1, stop 1), evt_ready=0 -> evt_valid=1, evt_data=10'h01D, evt_count=1, SYNC_STAGES+2 cycles after the stop edge.
2. Bytes E0,75 then E0,F0,75 -> evt_data 10'h175, then 10'h375 after pop. Prefix bytes alone create no events.
3. Frame 0x1D with parity 0 -> no event, frame_err=1. Pulse clr_err -> frame_err=0. A following good 0x1C -> evt_data=10'h01C.
4. FIFO_DEPTH=8: nine make codes 0x01..0x09 with evt_ready=0 -> evt_count=8, overflow=1. Pops return 0x01..0x08 in order. Full FIFO with pop and push in the same cycle -> count stays 8, overflow unchanged.
5. rst asserted after 4 data bits -> all outputs at reset values. Next full frame 0x6B -> evt_data=10'h06B.
6. With PS2_TIMEOUT_EN and TIMEOUT_CYCLES=100: start plus 5 bits, idle 120 cycles, then full frame 0x72 -> evt_data=10'h072 and frame_err=0. Without the macro, same stimulus -> no 0x072 event.
